// File: rtl/reg_dump_ctrl_if.sv
// rtl/reg_dump_ctrl_if.sv - register-file read port plus indexed output stream
// between the dump controller (master) and the reg file / trace sink (slave).
interface reg_dump_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rf_read_reg;
  logic [DATA_W-1:0] rf_read_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;

  modport master (
    output rf_read_reg,
    input  rf_read_data,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_index,
    output out_last
  );

  modport slave (
    input  rf_read_reg,
    output rf_read_data,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_index,
    input  out_last
  );
endinterface

// File: rtl/reg_dump_ctrl.sv
// rtl/reg_dump_ctrl.sv - walks a register range through the 1-cycle-latency reg file
// read port and streams each value with its index, ending with a done pulse.
module reg_dump_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int ZERO_R0 = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  input  logic              abort,
  reg_dump_ctrl_if.master   bus,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    PRESENT = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_index_q, out_index_d;
  logic              out_last_q, out_last_d;
  logic              err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      last_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (first_reg <= last_reg) begin
            idx_d   = first_reg;
            last_d  = last_reg;
            state_d = ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // Reg file registered idx at the ISSUE edge, so its data is valid now.
        out_data_d  = ((ZERO_R0 != 0) && (idx_q == '0)) ? '0 : bus.rf_read_data;
        out_index_d = idx_q;
        out_last_d  = (idx_q == last_q);
        out_valid_d = 1'b1;
        state_d     = PRESENT;
      end
      PRESENT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          // Testing before incrementing keeps idx from wrapping when last is the top index.
          if (idx_q == last_q) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ISSUE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end
  end

  assign bus.rf_read_reg = idx_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_index   = out_index_q;
  assign bus.out_last    = out_last_q;
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == DONE);
  assign err             = err_q;

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// tb/tb_reg_dump_ctrl.sv - table of dump scenarios checked beat by beat against a
// reg file model, plus hand sequences for latency, abort and reset mid-dump.
module tb_reg_dump_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] first_reg;
  logic [4:0] last_reg;
  logic       abort;
  logic       busy;
  logic       done;
  logic       err;

  logic [31:0] mem [32];

  int vecs  = 0;
  int fails = 0;

  reg_dump_ctrl_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  reg_dump_ctrl #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .first_reg (first_reg),
    .last_reg  (last_reg),
    .abort     (abort),
    .bus       (bus.master),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Reg file read port model: address sampled at posedge, data valid next cycle.
  always @(posedge clk) bus.rf_read_data <= mem[bus.rf_read_reg];

  typedef struct {
    logic [4:0] f;
    logic [4:0] l;
    int         stall;
    int         beats;
    logic       exp_err;
    int         done_cyc;
    int         inject;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input int i);
    return (i == 0) ? 32'h0 : mem[i];
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rf_read_reg"}, 32'(bus.rf_read_reg), 32'h0);
    chk({tag, "_out_valid"},   32'(bus.out_valid),   32'h0);
    chk({tag, "_out_data"},    bus.out_data,         32'h0);
    chk({tag, "_out_index"},   32'(bus.out_index),   32'h0);
    chk({tag, "_out_last"},    32'(bus.out_last),    32'h0);
    chk({tag, "_busy"},        32'(busy),            32'h0);
    chk({tag, "_done"},        32'(done),            32'h0);
    chk({tag, "_err"},         32'(err),             32'h0);
  endtask

  task automatic run_dump(input vec_t v, input int n);
    int   beats   = 0;
    int   waitc   = 0;
    int   done_at = -1;
    int   err_cnt = 0;
    int   ei      = int'(v.f);
    logic seen_valid = 1'b0;
    logic hs;
    first_reg = v.f;
    last_reg  = v.l;
    start     = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc == v.inject) begin
        start     = 1'b1;
        first_reg = 5'd0;
        last_reg  = 5'd31;
      end else begin
        start = 1'b0;
      end
      if (err) err_cnt++;
      if (done && done_at < 0) done_at = cyc;
      hs = 1'b0;
      if (bus.out_valid) begin
        seen_valid = 1'b1;
        chk($sformatf("v%0d_index", n), 32'(bus.out_index), ei);
        chk($sformatf("v%0d_data", n), bus.out_data, exp_data(ei & 31));
        chk($sformatf("v%0d_last", n), 32'(bus.out_last), 32'(ei == int'(v.l)));
        if (waitc < v.stall) begin
          bus.out_ready = 1'b0;
          waitc++;
        end else begin
          bus.out_ready = 1'b1;
          hs = 1'b1;
        end
      end else begin
        bus.out_ready = 1'b0;
      end
      @(negedge clk);
      if (hs) begin
        beats++;
        ei++;
        waitc = 0;
      end
      if (done_at >= 0 || (v.exp_err && cyc >= 4)) break;
    end
    start = 1'b0;
    bus.out_ready = 1'b0;
    chk($sformatf("v%0d_beats", n), beats, v.beats);
    chk($sformatf("v%0d_seen_valid", n), 32'(seen_valid), 32'(v.beats > 0));
    chk($sformatf("v%0d_err_cnt", n), err_cnt, v.exp_err ? 1 : 0);
    chk($sformatf("v%0d_done_cyc", n), done_at, v.done_cyc);
    chk($sformatf("v%0d_done_pulse", n), 32'(done), 32'h0);
    chk($sformatf("v%0d_busy_after", n), 32'(busy), 32'h0);
    chk($sformatf("v%0d_valid_after", n), 32'(bus.out_valid), 32'h0);
  endtask

  initial begin
    logic found;
    int   done_cnt;

    for (int i = 0; i < 32; i++) mem[i] = i * 32'h11111111;
    mem[0]  = 32'hDEADBEEF;
    mem[15] = 32'h01011066;

    vt[0] = '{5'd15, 5'd15, 0, 1,  1'b0, 3,  -1};
    vt[1] = '{5'd0,  5'd31, 0, 32, 1'b0, 96, -1};
    vt[2] = '{5'd4,  5'd6,  5, 3,  1'b0, 24, -1};
    vt[3] = '{5'd9,  5'd3,  0, 0,  1'b1, -1, -1};
    vt[4] = '{5'd31, 5'd31, 0, 1,  1'b0, 3,  -1};
    vt[5] = '{5'd0,  5'd0,  0, 1,  1'b0, 3,  -1};
    vt[6] = '{5'd7,  5'd9,  1, 3,  1'b0, 12, -1};
    vt[7] = '{5'd10, 5'd12, 0, 3,  1'b0, 9,  4};

    rst = 1'b1;
    start = 1'b0;
    first_reg = '0;
    last_reg = '0;
    abort = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("por");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_dump(vt[i], i);
      @(negedge clk);
    end

    // Single-register latency: valid rises after the second edge following start.
    first_reg = 5'd15;
    last_reg  = 5'd15;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("lat_e0_valid", 32'(bus.out_valid), 32'h0);
    chk("lat_e0_busy", 32'(busy), 32'h1);
    @(negedge clk);
    chk("lat_e1_valid", 32'(bus.out_valid), 32'h0);
    @(negedge clk);
    chk("lat_e2_valid", 32'(bus.out_valid), 32'h1);
    chk("lat_e2_data", bus.out_data, 32'h01011066);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("lat_done", 32'(done), 32'h1);
    @(negedge clk);
    chk("lat_done_clear", 32'(done), 32'h0);
    chk("lat_busy_clear", 32'(busy), 32'h0);

    // Abort coinciding with the handshake of idx 2 in a 0..7 dump.
    first_reg = 5'd0;
    last_reg  = 5'd7;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      if (bus.out_valid && bus.out_index == 5'd2) begin
        abort = 1'b1;
        bus.out_ready = 1'b1;
        found = 1'b1;
      end else begin
        bus.out_ready = bus.out_valid;
      end
      @(negedge clk);
    end
    abort = 1'b0;
    bus.out_ready = 1'b0;
    chk("abort_reached_idx2", 32'(found), 32'h1);
    chk("abort_valid", 32'(bus.out_valid), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    done_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (done || bus.out_valid) done_cnt++;
      @(negedge clk);
    end
    chk("abort_no_done", done_cnt, 0);
    run_dump('{5'd0, 5'd1, 0, 2, 1'b0, 6, -1}, 8);
    @(negedge clk);

    // Reset while in WAIT for idx 4 of a 3..7 dump.
    first_reg = 5'd3;
    last_reg  = 5'd7;
    start     = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pre_index", 32'(bus.out_index), 32'd3);
    repeat (2) @(negedge clk);
    chk("rst_pre_addr", 32'(bus.rf_read_reg), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b0;
    chk_reset_vals("mid");
    done_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (done || busy) done_cnt++;
      @(negedge clk);
    end
    chk("rst_silent", done_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
